// File: rtl/day_counter.sv
// Day-of-month stage of a calendar chain: counts days on carry_in from the hour
// stage, supports manual up/down adjust, and clamps the day when the month shrinks.
module day_counter (
  input  logic        clk_1Hz,
  input  logic        rst_n,
  input  logic        en_1,
  input  logic        adjust,
  input  logic        up,
  input  logic        down,
  input  logic        carry_in,
  input  logic [3:0]  month_bin,
  input  logic [13:0] year_bin,
  output logic [4:0]  day_bin,
  output logic        carry_out
);

  logic       up_s1, up_s2, up_prev;
  logic       dn_s1, dn_s2, dn_prev;
  logic [1:0] arm_cnt;
  logic       leap;
  logic [4:0] dim;
  logic       up_p, down_p;
  logic       count_ev, adj_up, adj_dn, adj_both;
  logic [4:0] day_nxt;
  logic       carry_nxt;

  // Leap rule: divisible by 4 but not by 100, or divisible by 400 (year 0 is leap).
  always_comb begin
    leap = (((year_bin % 14'd4) == 14'd0) && ((year_bin % 14'd100) != 14'd0)) ||
           ((year_bin % 14'd400) == 14'd0);
  end

  always_comb begin
    dim = 5'd31;
    case (month_bin)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = leap ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  end

  // arm_cnt counts edges since reset release. Count events need one edge; button
  // pulses need the synchronizer and edge detector primed so a button held through
  // reset release is seen as a level, not a press.
  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      up_s1   <= 1'b0;
      up_s2   <= 1'b0;
      up_prev <= 1'b0;
      dn_s1   <= 1'b0;
      dn_s2   <= 1'b0;
      dn_prev <= 1'b0;
      arm_cnt <= 2'd0;
    end else begin
      up_s1   <= up;
      up_s2   <= up_s1;
      up_prev <= up_s2;
      dn_s1   <= down;
      dn_s2   <= dn_s1;
      dn_prev <= dn_s2;
      if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  always_comb begin
    up_p     = up_s2 & ~up_prev & (arm_cnt == 2'd3);
    down_p   = dn_s2 & ~dn_prev & (arm_cnt == 2'd3);
    count_ev = en_1 & carry_in & ~adjust & (arm_cnt != 2'd0);
    adj_up   = adjust & up_p & ~down_p;
    adj_dn   = adjust & down_p & ~up_p;
    adj_both = adjust & up_p & down_p;
  end

  // Priority: count event, adjust action, clamp, hold.
  always_comb begin
    day_nxt   = day_bin;
    carry_nxt = 1'b0;
    if (count_ev) begin
      if (day_bin >= dim) begin
        day_nxt   = 5'd1;
        carry_nxt = 1'b1;
      end else begin
        day_nxt = day_bin + 5'd1;
      end
    end else if (adj_up) begin
      day_nxt = (day_bin >= dim) ? 5'd1 : day_bin + 5'd1;
    end else if (adj_dn) begin
      day_nxt = ((day_bin == 5'd1) || (day_bin > dim)) ? dim : day_bin - 5'd1;
    end else if (adj_both) begin
      day_nxt = day_bin;
    end else if (day_bin > dim) begin
      day_nxt = dim;
    end
  end

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      day_bin   <= 5'd1;
      carry_out <= 1'b0;
    end else begin
      day_bin   <= day_nxt;
      carry_out <= carry_nxt;
    end
  end

endmodule

// File: doc/day_counter.md
DAY_COUNTER -- requirements
Module: day_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clk_1Hz, except reset, which acts immediately on rst_n low.
REQ-002 clk_1Hz  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en_1  input  1  count enable; count events are accepted only when en_1 is high.
REQ-005 adjust  input  1  mode select: 0 = count, 1 = manual adjust.
REQ-006 up  input  1  raw increment button; asynchronous to clk_1Hz.
REQ-007 down  input  1  raw decrement button; asynchronous to clk_1Hz.
REQ-008 carry_in  input  1  day-rollover pulse from the hour stage.
REQ-009 month_bin  input  4  current month, 1..12, from the month stage.
REQ-010 year_bin  input  14  current year, 0..9999, from the year stage.
REQ-011 day_bin  output  5  current day of month, 1..31, registered.
REQ-012 carry_out  output  1  month-advance pulse to the month stage, registered.

Function
REQ-013 Days-in-month (dim) SHALL be combinational: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 29 for month 2 in a leap year; 28 for month 2 otherwise.
REQ-014 month_bin values 0 and 13..15 SHALL give dim = 31.
REQ-015 A year SHALL be leap when (year mod 4 = 0 and year mod 100 != 0) or year mod 400 = 0; year 0 SHALL be leap.
REQ-016 up and down SHALL each pass through a two-flop synchronizer followed by a rising-edge detector; each detected edge SHALL yield exactly one one-cycle pulse (up_p, down_p).
REQ-017 Count event: a cycle with en_1=1, carry_in=1 and adjust=0.
REQ-018 On a count event with day_bin >= dim: next day_bin = 1 and carry_out = 1.
REQ-019 On a count event with day_bin < dim: next day_bin = day_bin + 1 and carry_out = 0.
REQ-020 carry_out SHALL be 0 in every cycle without a count event; it is a single-cycle pulse with one cycle of latency from carry_in.
REQ-021 With adjust=1, carry_in SHALL be ignored and carry_out SHALL stay 0.
REQ-022 Adjust up (adjust=1, up_p=1, down_p=0): day_bin >= dim gives 1; otherwise day_bin + 1.
REQ-023 Adjust down (adjust=1, down_p=1, up_p=0): day_bin = 1 gives dim; day_bin > dim gives dim; otherwise day_bin - 1.
REQ-024 up_p and down_p in the same cycle SHALL leave day_bin unchanged.
REQ-025 Button edges while adjust=0 SHALL be discarded; en_1 SHALL NOT gate adjust actions.
REQ-026 Clamp: in any cycle with no count event and no adjust action, if day_bin > dim, day_bin SHALL become dim on the next edge (covers a month or leap-year change under a held day).
REQ-027 Priority, highest first: reset, count event, adjust action, clamp, hold.
REQ-028 day_bin SHALL never leave 1..31 and SHALL never be 0 after reset.

Reset
REQ-029 rst_n low SHALL immediately force day_bin = 1, carry_out = 0, and clear all synchronizer and edge-detect flops.
REQ-030 Reset asserted mid-count or mid-adjust SHALL abort the operation with no carry_out pulse.
REQ-031 After rst_n rises, the first count event or adjust action SHALL be honoured no earlier than the second clock edge.

Verification
REQ-032 month=1, day=31, en_1=1, carry_in pulse -> day_bin = 1 and carry_out high for exactly 1 cycle.
REQ-033 month=2, year=2024, day=28, carry_in pulse -> day_bin = 29, carry_out = 0; a second pulse -> day_bin = 1, carry_out = 1.
REQ-034 month=2, years 1900, 2000 and 2023, day=28, carry_in pulse -> day_bin = 1, 29 and 1 respectively.
REQ-035 adjust=1, day=1, month=4, one down press -> day_bin = 30; one up press -> day_bin = 1; up and down pressed together -> no change; carry_out stays 0 throughout.
REQ-036 day=31 held, month_bin changes from 3 to 4 -> day_bin = 30 on the next edge; carry_in with adjust=1 -> no change and no carry_out.
REQ-037 rst_n pulsed low between clock edges during counting -> day_bin = 1 and carry_out = 0 immediately; up held high through reset release produces no adjust step.
